// File: rtl/ecg_axis_sample_source.sv
// AXI-Stream sample source: forwards strobed ADC samples or generates impulse/step/zero
// test patterns at a CLK_DIV tick rate, buffered in a small FIFO against backpressure.
module ecg_axis_sample_source #(
  parameter int                    DATA_WIDTH    = 16,
  parameter int                    CLK_DIV       = 100,
  parameter int                    FIFO_DEPTH    = 4,
  parameter logic [DATA_WIDTH-1:0] IMPULSE_VALUE = 16'h7FFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic                  start,
  input  logic                  stop,
  input  logic [DATA_WIDTH-1:0] adc_tdata,
  input  logic                  adc_valid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  overflow,
  output logic [15:0]           sample_count
);

  localparam int                ADDR_W     = $clog2(FIFO_DEPTH);
  localparam int                CNT_W      = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0]  TICK_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  state_r, state_s;
  logic                    arm_s;
  logic                    run_active_s;
  logic                    tick_s;
  logic [1:0]              run_mode_r;
  logic                    first_pending_r;
  logic [CNT_W-1:0]        tick_cnt_r;
  logic                    overflow_r;
  logic [15:0]             sample_count_r;

  logic                    push_req_s;
  logic [DATA_WIDTH-1:0]   push_data_s;
  logic                    pop_s;
  logic                    full_s;
  logic                    push_ok_s;
  logic                    drop_s;
  logic [ADDR_W-1:0]       rd_next_s;
  logic [ADDR_W:0]         count_next_s;
  logic [DATA_WIDTH-1:0]   head_next_s;

  logic [DATA_WIDTH-1:0]   mem_r [FIFO_DEPTH];
  logic [ADDR_W-1:0]       wr_ptr_r;
  logic [ADDR_W-1:0]       rd_ptr_r;
  logic [ADDR_W:0]         count_r;
  logic                    valid_r;
  logic [DATA_WIDTH-1:0]   tdata_r;

  // Next-state logic: stop dominates start; start while running re-arms in place.
  always_comb begin
    state_s = state_r;
    arm_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && !stop) begin
          state_s = ST_RUN;
          arm_s   = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_s = ST_IDLE;
        end else if (start) begin
          state_s = ST_RUN;
          arm_s   = 1'b1;
        end else begin
          state_s = ST_RUN;
        end
      end
      default: begin
        state_s = ST_IDLE;
        arm_s   = 1'b0;
      end
    endcase
  end

  // Pushes happen only in steady RUN cycles; a start/stop cycle is a control-only cycle.
  assign run_active_s = (state_r == ST_RUN) && !start && !stop;
  assign tick_s       = run_active_s && (tick_cnt_r == TICK_LAST);

  // Push source selection from the latched run mode.
  always_comb begin
    push_req_s  = 1'b0;
    push_data_s = {DATA_WIDTH{1'b0}};
    if (run_active_s) begin
      case (run_mode_r)
        2'd0: begin
          push_req_s  = adc_valid;
          push_data_s = adc_tdata;
        end
        2'd1: begin
          push_req_s  = tick_s;
          push_data_s = first_pending_r ? IMPULSE_VALUE : {DATA_WIDTH{1'b0}};
        end
        2'd2: begin
          push_req_s  = tick_s;
          push_data_s = IMPULSE_VALUE;
        end
        2'd3: begin
          push_req_s  = tick_s;
          push_data_s = {DATA_WIDTH{1'b0}};
        end
        default: begin
          push_req_s  = 1'b0;
          push_data_s = {DATA_WIDTH{1'b0}};
        end
      endcase
    end else begin
      push_req_s  = 1'b0;
      push_data_s = {DATA_WIDTH{1'b0}};
    end
  end

  // FIFO bookkeeping; the next head is precomputed so the output stays a plain register.
  always_comb begin
    pop_s     = valid_r && m_axis_tready;
    full_s    = (count_r == FULL_COUNT);
    push_ok_s = push_req_s && (!full_s || pop_s);
    drop_s    = push_req_s && !push_ok_s;
    if (pop_s) begin
      rd_next_s = rd_ptr_r + ADDR_W'(1'b1);
    end else begin
      rd_next_s = rd_ptr_r;
    end
    case ({push_ok_s, pop_s})
      2'b10:   count_next_s = count_r + (ADDR_W + 1)'(1'b1);
      2'b01:   count_next_s = count_r - (ADDR_W + 1)'(1'b1);
      default: count_next_s = count_r;
    endcase
    if (push_ok_s && (wr_ptr_r == rd_next_s)) begin
      head_next_s = push_data_s;
    end else begin
      head_next_s = mem_r[rd_next_s];
    end
  end

  // Control registers: state, latched mode, tick counter, status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      run_mode_r      <= 2'd0;
      first_pending_r <= 1'b0;
      tick_cnt_r      <= {CNT_W{1'b0}};
      overflow_r      <= 1'b0;
      sample_count_r  <= 16'd0;
    end else begin
      state_r <= state_s;
      if (arm_s) begin
        run_mode_r      <= mode;
        first_pending_r <= 1'b1;
        tick_cnt_r      <= {CNT_W{1'b0}};
        overflow_r      <= 1'b0;
        sample_count_r  <= 16'd0;
      end else begin
        if (!run_active_s || tick_s) begin
          tick_cnt_r <= {CNT_W{1'b0}};
        end else begin
          tick_cnt_r <= tick_cnt_r + CNT_W'(1'b1);
        end
        if (tick_s) begin
          first_pending_r <= 1'b0;
        end
        if (drop_s) begin
          overflow_r <= 1'b1;
        end
        if (push_ok_s) begin
          sample_count_r <= sample_count_r + 16'd1;
        end
      end
    end
  end

  // FIFO storage array.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data_s;
    end
  end

  // FIFO pointers, occupancy and registered output stage (tdata holds when empty).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {ADDR_W{1'b0}};
      rd_ptr_r <= {ADDR_W{1'b0}};
      count_r  <= {(ADDR_W + 1){1'b0}};
      valid_r  <= 1'b0;
      tdata_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_W'(1'b1);
      end
      rd_ptr_r <= rd_next_s;
      count_r  <= count_next_s;
      valid_r  <= (count_next_s != {(ADDR_W + 1){1'b0}});
      if (count_next_s != {(ADDR_W + 1){1'b0}}) begin
        tdata_r <= head_next_s;
      end
    end
  end

  assign m_axis_tdata  = tdata_r;
  assign m_axis_tvalid = valid_r;
  assign overflow      = overflow_r;
  assign sample_count  = sample_count_r;

endmodule

// File: tb/tb_ecg_axis_sample_source.sv
// Self-checking bench for ecg_axis_sample_source: directed scenarios plus a randomized
// run compared against a queue-based reference model of the source.
module tb_ecg_axis_sample_source;

  localparam int          DW    = 16;
  localparam int          DIV   = 4;
  localparam int          DEPTH = 4;
  localparam logic [15:0] IMP   = 16'h7FFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [DW-1:0] adc_tdata = 16'h0000;
  logic          adc_valid = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          overflow;
  logic [15:0]   sample_count;

  int checks = 0;
  int passes = 0;

  // Reference model state
  logic [15:0] mq[$];
  logic        m_run = 1'b0;
  logic [1:0]  m_mode = 2'd0;
  logic        m_fp = 1'b0;
  logic        m_ovf = 1'b0;
  logic [15:0] m_cnt = 16'h0000;
  logic [15:0] m_last = 16'h0000;
  int          m_since = 0;

  ecg_axis_sample_source #(
    .DATA_WIDTH(DW), .CLK_DIV(DIV), .FIFO_DEPTH(DEPTH), .IMPULSE_VALUE(IMP)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .start(start), .stop(stop),
    .adc_tdata(adc_tdata), .adc_valid(adc_valid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .overflow(overflow), .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  // Model: samples are produced every DIV cycles counted from the start edge.
  task automatic model_edge();
    logic        pop, req, active;
    logic [15:0] d;
    int          sz;
    if (rst) begin
      mq.delete();
      m_run = 1'b0; m_fp = 1'b0; m_ovf = 1'b0; m_cnt = 16'h0000;
      m_last = 16'h0000; m_since = 0;
    end else begin
      sz     = mq.size();
      pop    = (sz != 0) && m_axis_tready;
      active = m_run && !start && !stop;
      req    = 1'b0;
      d      = 16'h0000;
      if (active) begin
        if (m_mode == 2'd0) begin
          req = adc_valid; d = adc_tdata;
        end else if ((m_since % DIV) == DIV - 1) begin
          req = 1'b1;
          d = ((m_mode == 2'd2) || (m_mode == 2'd1 && m_fp)) ? IMP : 16'h0000;
          m_fp = 1'b0;
        end
        m_since++;
      end
      if (pop) m_last = mq.pop_front();
      if (req) begin
        if (sz < DEPTH || pop) begin
          mq.push_back(d);
          m_cnt = m_cnt + 16'd1;
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (stop) begin
        m_run = 1'b0;
      end else if (start) begin
        m_run = 1'b1; m_mode = mode; m_fp = 1'b1; m_ovf = 1'b0;
        m_cnt = 16'h0000; m_since = 0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mode = 2'($urandom_range(0, 3)); start = 1'($urandom_range(0, 1));
      stop = 1'($urandom_range(0, 1)); adc_valid = 1'($urandom_range(0, 1));
      adc_tdata = 16'($urandom); m_axis_tready = 1'($urandom_range(0, 1));
      cycle();
      checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); else passes++;
      checks++; if (m_axis_tdata !== 16'h0000) $display("FAIL reset_tdata: got %h want 0000", m_axis_tdata); else passes++;
      checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else passes++;
      checks++; if (sample_count !== 16'h0000) $display("FAIL reset_count: got %0d want 0", sample_count); else passes++;
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; m_axis_tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      adc_valid = 1'($urandom_range(0, 1)); adc_tdata = 16'($urandom); mode = 2'($urandom_range(0, 3));
      cycle();
      checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL idle_no_push: got tvalid %b want 0", m_axis_tvalid); else passes++;
    end
    adc_valid = 1'b0;
  endtask

  task automatic test_impulse();
    m_axis_tready = 1'b1; mode = 2'd1; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int e = 1; e <= 17; e++) begin
      cycle();
      checks++;
      if (m_axis_tvalid !== (e == 4 || e == 8 || e == 12 || e == 16))
        $display("FAIL impulse_tvalid: edge %0d got %b", e, m_axis_tvalid);
      else passes++;
      if (e == 4 || e == 8 || e == 12 || e == 16) begin
        checks++;
        if (m_axis_tdata !== ((e == 4) ? IMP : 16'h0000))
          $display("FAIL impulse_tdata: edge %0d got %h want %h", e, m_axis_tdata, (e == 4) ? IMP : 16'h0000);
        else passes++;
      end
      if (e == 16) begin
        checks++; if (sample_count !== 16'd4) $display("FAIL impulse_count: got %0d want 4", sample_count); else passes++;
      end
    end
    stop = 1'b1; cycle(); stop = 1'b0;
  endtask

  task automatic test_step_stop();
    m_axis_tready = 1'b1; mode = 2'd2; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      stop = (e == 10);
      cycle();
      checks++;
      if (m_axis_tvalid !== (e == 4 || e == 8))
        $display("FAIL step_tvalid: edge %0d got %b", e, m_axis_tvalid);
      else passes++;
      if (e == 4 || e == 8) begin
        checks++; if (m_axis_tdata !== IMP) $display("FAIL step_tdata: got %h want %h", m_axis_tdata, IMP); else passes++;
      end
    end
    stop = 1'b0;
    checks++; if (sample_count !== 16'd2) $display("FAIL step_count: got %0d want 2", sample_count); else passes++;
  endtask

  task automatic test_overflow();
    m_axis_tready = 1'b0; mode = 2'd0; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      adc_valid = 1'b1; adc_tdata = 16'(v);
      cycle();
    end
    adc_valid = 1'b0;
    checks++; if (m_axis_tvalid !== 1'b1) $display("FAIL ovf_tvalid: got %b want 1", m_axis_tvalid); else passes++;
    checks++; if (m_axis_tdata !== 16'h0001) $display("FAIL ovf_tdata: got %h want 0001", m_axis_tdata); else passes++;
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow); else passes++;
    checks++; if (sample_count !== 16'd4) $display("FAIL ovf_count: got %0d want 4", sample_count); else passes++;
    m_axis_tready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'(k))
        $display("FAIL ovf_drain: got valid %b data %h want 1 %h", m_axis_tvalid, m_axis_tdata, 16'(k));
      else passes++;
      cycle();
    end
    checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL ovf_empty: got %b want 0", m_axis_tvalid); else passes++;
    checks++; if (m_axis_tdata !== 16'h0004) $display("FAIL hold_last: got %h want 0004", m_axis_tdata); else passes++;
  endtask

  task automatic test_full_push_pop();
    m_axis_tready = 1'b0; mode = 2'd0; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int v = 10; v <= 13; v++) begin
      adc_valid = 1'b1; adc_tdata = 16'(v);
      cycle();
    end
    checks++; if (overflow !== 1'b0) $display("FAIL full_restart_ovf: got %b want 0", overflow); else passes++;
    checks++; if (m_axis_tdata !== 16'd10) $display("FAIL full_head: got %h want 000a", m_axis_tdata); else passes++;
    m_axis_tready = 1'b1; adc_valid = 1'b1; adc_tdata = 16'd14;
    cycle();
    m_axis_tready = 1'b0; adc_valid = 1'b0;
    checks++; if (overflow !== 1'b0) $display("FAIL full_pp_ovf: got %b want 0", overflow); else passes++;
    checks++; if (sample_count !== 16'd5) $display("FAIL full_pp_count: got %0d want 5", sample_count); else passes++;
    m_axis_tready = 1'b1;
    for (int k = 11; k <= 14; k++) begin
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'(k))
        $display("FAIL full_order: got valid %b data %h want 1 %h", m_axis_tvalid, m_axis_tdata, 16'(k));
      else passes++;
      cycle();
    end
    checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL full_occupancy: got tvalid %b want 0", m_axis_tvalid); else passes++;
  endtask

  task automatic test_start_stop_rst();
    m_axis_tready = 1'b0; start = 1'b1; stop = 1'b1;
    cycle();
    start = 1'b0; stop = 1'b0; adc_valid = 1'b1; adc_tdata = 16'd99;
    cycle();
    adc_valid = 1'b0;
    checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL startstop_idle: got tvalid %b want 0", m_axis_tvalid); else passes++;
    checks++; if (sample_count !== 16'd5) $display("FAIL startstop_count: got %0d want 5", sample_count); else passes++;
    mode = 2'd0; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int v = 21; v <= 23; v++) begin
      adc_valid = 1'b1; adc_tdata = 16'(v);
      cycle();
    end
    adc_valid = 1'b0;
    checks++; if (sample_count !== 16'd3) $display("FAIL prerst_count: got %0d want 3", sample_count); else passes++;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b want 0", m_axis_tvalid); else passes++;
    checks++; if (sample_count !== 16'd0) $display("FAIL rst_count: got %0d want 0", sample_count); else passes++;
    checks++; if (m_axis_tdata !== 16'h0000) $display("FAIL rst_tdata: got %h want 0000", m_axis_tdata); else passes++;
  endtask

  task automatic test_random();
    logic [15:0] exp_d;
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      start     = ($urandom_range(0, 39) == 0);
      stop      = ($urandom_range(0, 69) == 0);
      mode      = 2'($urandom_range(0, 3));
      adc_valid = ($urandom_range(0, 2) == 0);
      adc_tdata = 16'($urandom);
      m_axis_tready = ((i % 200) < 100) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      cycle();
      exp_d = (mq.size() != 0) ? mq[0] : m_last;
      checks++; if (m_axis_tvalid !== (mq.size() != 0)) $display("FAIL rand_tvalid: cycle %0d got %b want %b", i, m_axis_tvalid, mq.size() != 0); else passes++;
      checks++; if (m_axis_tdata !== exp_d) $display("FAIL rand_tdata: cycle %0d got %h want %h", i, m_axis_tdata, exp_d); else passes++;
      checks++; if (overflow !== m_ovf) $display("FAIL rand_overflow: cycle %0d got %b want %b", i, overflow, m_ovf); else passes++;
      checks++; if (sample_count !== m_cnt) $display("FAIL rand_count: cycle %0d got %0d want %0d", i, sample_count, m_cnt); else passes++;
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; adc_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_step_stop();
    test_overflow();
    test_full_push_pop();
    test_start_stop_rst();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
